// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared across the MIPS core.
//  - opcode / funct encodings used by the decode-stage control unit
//  - NOP_INSTR: canonical bubble (sll $0,$0,0)
//  - fetch_state_e: fetch-stage FSM encoding
//  - RESET_PC_DEFAULT: default fetch start address
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding at pc
    DRAIN = 2'd1,  // waiting out a request made stale by a redirect
    HOLD  = 2'd2   // fetched word parked in skid, decode stalled
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register (valid, instruction, pc+4).
// Priority: reset > flush > load > hold > bubble.
//  clk, reset        clock, synchronous active-high reset
//  flush             drop the current slot (redirect)
//  load              capture load_instr / load_pc_plus4 as a valid slot
//  hold              decode stalled; a valid slot keeps its contents
//  load_instr        instruction word to capture
//  load_pc_plus4     pc+4 of that instruction
//  valid             slot holds a real instruction
//  instr             slot instruction, NOP_INSTR whenever !valid
//  pc_plus4          pc+4 of the slot instruction
module if_id_reg
  import mips_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                load,
  input  logic                hold,
  input  logic [31:0]         load_instr,
  input  logic [PC_WIDTH-1:0] load_pc_plus4,
  output logic                valid,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] pc_plus4
);

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= load_instr;
      pc_plus4 <= load_pc_plus4;
    end else if (!(hold && valid)) begin
      // Decode consumed the slot and nothing replaces it: insert a bubble.
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_if_id_stage.sv
// fetch_if_id_stage: instruction fetch + IF/ID register of the MIPS core.
// Holds the PC, issues requests to a variable-latency instruction memory,
// handles branch redirect and downstream stall, and exposes decode fields.
//  clk, reset                  clock, synchronous active-high reset
//  imem_req, imem_addr         fetch request; held stable until imem_valid
//  imem_valid, imem_rdata      memory response strobe and instruction word
//  stall                       decode cannot accept; IF/ID holds
//  branch_taken, branch_target redirect request and target (low bits ignored)
//  instr_valid, instr          IF/ID slot (instr is NOP when invalid)
//  pc_plus4                    pc+4 of the IF/ID instruction
//  op, rs, rt, rd, funct, imm16  decode fields wired from instr
module fetch_if_id_stage
  import mips_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic [5:0]          op,
  output logic [5:0]          funct,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [15:0]         imm16
);

  fetch_state_e        state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic [PC_WIDTH-1:0] redir_pc, redir_pc_nxt;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] target_aligned;

  logic [31:0]         skid_instr;
  logic [PC_WIDTH-1:0] skid_pc_plus4;
  logic                skid_load;

  logic                id_load;
  logic [31:0]         id_load_instr;
  logic [PC_WIDTH-1:0] id_load_pc_plus4;

  assign pc_inc         = pc + PC_WIDTH'(4);  // wraps modulo 2^PC_WIDTH
  assign target_aligned = branch_target & ~PC_WIDTH'(3);
  assign imem_addr      = pc;

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    redir_pc_nxt     = redir_pc;
    skid_load        = 1'b0;
    id_load          = 1'b0;
    id_load_instr    = imem_rdata;
    id_load_pc_plus4 = pc_inc;
    imem_req         = 1'b0;

    unique case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          if (imem_valid) begin
            pc_nxt = target_aligned;       // word arrived: drop it, refetch now
          end else begin
            redir_pc_nxt = target_aligned; // request in flight: wait it out
            state_nxt    = DRAIN;
          end
        end else if (imem_valid) begin
          pc_nxt = pc_inc;
          if (!instr_valid || !stall) begin
            id_load = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      DRAIN: begin
        // The stale request stays asserted until the memory answers it.
        imem_req = 1'b1;
        if (branch_taken) redir_pc_nxt = target_aligned;
        if (imem_valid) begin
          pc_nxt    = branch_taken ? target_aligned : redir_pc;
          state_nxt = FETCH;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_nxt    = target_aligned;
          state_nxt = FETCH;
        end else if (!stall) begin
          id_load          = 1'b1;
          id_load_instr    = skid_instr;
          id_load_pc_plus4 = skid_pc_plus4;
          state_nxt        = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase

    if (reset) imem_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      redir_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      redir_pc <= redir_pc_nxt;
    end
  end

  // NOTE: skid data has no reset; it is only read in HOLD, and reset
  // forces FETCH, so the buffer is logically empty after reset.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_instr    <= imem_rdata;
      skid_pc_plus4 <= pc_inc;
    end
  end

  if_id_reg #(
    .PC_WIDTH(PC_WIDTH)
  ) u_if_id (
    .clk          (clk),
    .reset        (reset),
    .flush        (branch_taken),
    .load         (id_load),
    .hold         (stall),
    .load_instr   (id_load_instr),
    .load_pc_plus4(id_load_pc_plus4),
    .valid        (instr_valid),
    .instr        (instr),
    .pc_plus4     (pc_plus4)
  );

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign imm16 = instr[15:0];
  assign funct = instr[5:0];

endmodule
